// File: rtl/timer_counter.sv
// Memory-mapped count-down timer with CTRL/PRESET/COUNT registers and a maskable interrupt.
// Word writes only; reads are combinational from the current register values.
module timer_counter #(
  parameter logic [31:0] BASE = 32'h0000_7f00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   ctrl_q, ctrl_d;
  logic [DW-1:0]   preset_q, preset_d;
  logic [DW-1:0]   count_q, count_d;
  logic            irq_flag_q, irq_flag_d;

  logic            sel, wr, wr_ctrl, wr_preset;
  logic            en, auto_reload;
  logic            unused_addr_lo;

  assign unused_addr_lo = ^addr[1:0];

  assign sel       = (addr[31:4] == BASE[31:4]) && (addr[3:2] != 2'b11);
  assign wr        = sel && (byteen == 4'b1111);
  assign wr_ctrl   = wr && (addr[3:2] == 2'b00);
  assign wr_preset = wr && (addr[3:2] == 2'b01);

  assign en          = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);

  // State and register file
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_CNT;
      ST_CNT: begin
        if (!en)                     state_d = ST_IDLE;
        else if (count_q <= DW'(1))  state_d = ST_INT;
      end
      ST_INT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Register updates; CPU writes are applied last so they win over FSM side effects
  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    case (state_q)
      ST_LOAD: count_d = preset_q;
      ST_CNT: begin
        if (en) begin
          if (count_q > DW'(1)) begin
            count_d = count_q - DW'(1);
          end else begin
            count_d    = '0;
            irq_flag_d = 1'b1;
          end
        end
      end
      ST_INT: begin
        if (auto_reload) irq_flag_d = 1'b0;
        else             ctrl_d[0]  = 1'b0;
      end
      default: ;
    endcase
    if (wr_ctrl) begin
      ctrl_d     = wdata[CW-1:0];
      irq_flag_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d   = wdata;
      irq_flag_d = 1'b0;
    end
  end

  // Read mux and interrupt output
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr[3:2])
        2'b00:   rdata = {{(DW-CW){1'b0}}, ctrl_q};
        2'b01:   rdata = preset_q;
        2'b10:   rdata = count_q;
        default: rdata = '0;
      endcase
    end
    irq = irq_flag_q & ctrl_q[3];
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped timer/counter that sits on the far (responder) side of the CPU data bus. It decodes word accesses from the CPU's data address, byte-enable, write-data and read-data lines, and exposes three registers: CTRL, PRESET and COUNT. It runs a count-down state machine. Its interrupt line feeds one bit of the CPU hardware-interrupt vector.

## Interface
Parameters:
- BASE, 32'h0000_7f00, byte address of CTRL. PRESET is at BASE+4 and COUNT is at BASE+8.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (fixed: one clock, async active-low reset).
- addr  in  32  CPU data address.
- byteen  in  4  CPU write byte enables; 4'b0000 means no write.
- wdata  in  32  CPU write data.
- rdata  out  32  read data for the addressed register.
- irq  out  1  interrupt request to the CPU.

## Operation
- Select: sel = (addr[31:4] == BASE[31:4]) && (addr[3:2] != 2'b11).
- A write occurs only when sel is true and byteen == 4'b1111.
  - Partial byte enables are ignored; the CPU already flags them as AdES.
- Register map, by addr[3:2]:
  - 00 CTRL: bits [3:0] are stored; bits [31:4] read as 0.
    - bit 0 EN: counting enable.
    - bits [2:1] MODE: 00 = one-shot, 01 = auto-reload, 1x = treated as one-shot.
    - bit 3 IM: interrupt mask, 1 = enabled.
  - 01 PRESET: 32-bit read/write.
  - 10 COUNT: 32-bit, read-only; writes are ignored.
  - 11 unmapped: reads as 0.
- Read path is combinational: rdata = mux(addr[3:2]) of the current register values. rdata = 0 when sel is false.
- irq = irq_flag & CTRL.IM.
- State machine, state ∈ {IDLE, LOAD, CNT, INT}:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If !EN, go to IDLE; COUNT holds its value.
    - Else if COUNT > 1, COUNT <= COUNT-1.
    - Else COUNT <= 0, irq_flag <= 1, go to INT.
  - INT, one-shot mode: EN <= 0, go to IDLE; irq_flag stays 1.
  - INT, auto-reload mode: irq_flag <= 0, go to IDLE; EN is kept, so the timer reloads.
- irq_flag is cleared by any accepted write to CTRL or PRESET.
- Priority: a CPU write to CTRL on the same edge as the INT-state EN clear wins, and the written EN is kept.
- Writing PRESET during CNT does not change COUNT. The new value takes effect at the next LOAD.
- COUNT is an unsigned 32-bit value.
  - PRESET = 0 behaves like PRESET = 1: COUNT is loaded as 0 and INT follows on the next edge.
  - There is no wrap-around.

## Timing
- Reset values (asynchronous, on reset == 0): CTRL = 0, PRESET = 0, COUNT = 0, state = IDLE, irq_flag = 0.
  - Hence irq = 0 and rdata = 0 during reset.
- Reset asserted mid-count takes effect immediately, without waiting for a clock edge.
- Register writes are visible on rdata from the cycle after the write edge. Read latency is 0 cycles.
- Let the CTRL write that sets EN occur at edge E0:
  - LOAD at E1, CNT at E2 with COUNT = PRESET.
  - irq rises after edge E0 + max(PRESET,1) + 2.
- One-shot mode: irq stays high until the next CTRL or PRESET write. That write clears irq at its own edge.
- Auto-reload mode: irq is high for exactly 1 cycle. The period is max(PRESET,1) + 3 cycles.
- Clearing EN in CNT stops counting from the next edge. Setting EN again restarts through LOAD from PRESET.

## Test plan
- Reset sequence: hold reset = 0 with random bus traffic; release it. Required: rdata for CTRL, PRESET and COUNT all read 0, and irq = 0.
- One-shot count: PRESET = 5, then CTRL = 32'h9.
  - COUNT reads 5,4,3,2,1,0 on successive cycles starting at E2; irq rises after E7; CTRL then reads 32'h8.
  - A later write CTRL = 0 drops irq.
- Auto-reload: PRESET = 3, CTRL = 32'hB. Required: irq pulses 1 cycle wide, first after E5, then every 6 cycles; EN stays 1.
- Masking and partial writes:
  - CTRL = 32'h1 (IM = 0), PRESET = 2: irq_flag sets but irq stays 0.
  - A write to PRESET with byteen = 4'b0011 leaves PRESET unchanged.
  - A write to COUNT is ignored.
- Mid-operation events:
  - PRESET write during CNT leaves COUNT's decrement sequence unchanged.
  - CTRL = 0 at COUNT = 3 freezes COUNT at 3.
  - Pulling reset low at COUNT = 3 zeroes COUNT before the next clock edge.
- Address decode: an access to BASE+12 or BASE+16 returns rdata = 0, and writes there change no register.
